// File: rtl/store_drain_queue_if.sv
// Shared types and the commit/memory/load-query bundle for store_drain_queue.
// The package travels with the interface so both sides agree on ldst_mode.
package store_drain_queue_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } ldst_mode;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;
endpackage

interface store_drain_queue_if;
    import store_drain_queue_pkg::*;

    logic        store_enable;
    ldst_mode    store_mode;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        mem_req;
    logic        mem_ack;
    ldst_mode    mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        load_query;
    ldst_mode    load_mode;
    logic [31:0] load_addr;
    logic        load_conflict;
    logic        fwd_valid;
    logic [31:0] fwd_data;

    modport slave (
        input  store_enable, store_mode, store_addr, store_data,
        input  mem_ack, load_query, load_mode, load_addr,
        output full, empty, overflow, mem_req, mem_mode, mem_addr, mem_data,
        output load_conflict, fwd_valid, fwd_data
    );

    modport master (
        output store_enable, store_mode, store_addr, store_data,
        output mem_ack, load_query, load_mode, load_addr,
        input  full, empty, overflow, mem_req, mem_mode, mem_addr, mem_data,
        input  load_conflict, fwd_valid, fwd_data
    );
endinterface

// File: rtl/store_drain_queue.sv
// Commit-side store buffer: in-order FIFO drained over mem_req/mem_ack, plus a load-address hazard query.
// Optional macro STORE_FWD_EN enables word store-to-load forwarding from the youngest matching entry.
module store_drain_queue
    import store_drain_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    store_drain_queue_if.slave  bus,
    output drain_state_t        dbg_state
);

    localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

    drain_state_t         state_q, state_d;
    logic [DEPTH_LOG-1:0] head_q, tail_q;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 overflow_q;

    ldst_mode             mode_q [DEPTH];
    logic [31:0]          addr_q [DEPTH];
    logic [31:0]          data_q [DEPTH];

    logic                 push, pop, drop;
    logic                 hit;
    logic [DEPTH_LOG-1:0] hit_idx, scan_idx;

    // Handshake: mem_req is the valid for the head entry and mem_ack the ready;
    // a transfer (pop) happens on an edge where both are high, and mem_* hold
    // steady while mem_req is high and mem_ack is low.
    assign pop  = (state_q == REQ) && bus.mem_ack;
    assign push = bus.store_enable && ((count_q != FULL_COUNT) || pop);
    assign drop = bus.store_enable && (count_q == FULL_COUNT) && !pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM next state and its registered-only memory outputs.
    always_comb begin
        state_d      = state_q;
        bus.mem_req  = 1'b0;
        bus.mem_mode = BYTE;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        unique case (state_q)
            IDLE: begin
                if (count_d != '0) state_d = REQ;
            end
            REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_mode = mode_q[head_q];
                bus.mem_addr = addr_q[head_q];
                bus.mem_data = data_q[head_q];
                if (pop && (count_d == '0)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) tail_q <= tail_q + DEPTH_LOG'(1);
            if (pop)  head_q <= head_q + DEPTH_LOG'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Entry payload needs no reset: validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mode_q[tail_q] <= bus.store_mode;
            addr_q[tail_q] <= bus.store_addr;
            data_q[tail_q] <= bus.store_data;
        end
    end

    assign bus.full     = (count_q == FULL_COUNT);
    assign bus.empty    = (count_q == '0);
    assign bus.overflow = overflow_q;
    assign dbg_state    = state_q;

    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + DEPTH_LOG'(k);
            if (((DEPTH_LOG + 1)'(k) < count_q) &&
                (addr_q[scan_idx][31:2] == bus.load_addr[31:2])) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

`ifdef STORE_FWD_EN
    logic fwd_ok;

    always_comb begin
        fwd_ok = hit && (mode_q[hit_idx] == WORD) &&
                 (addr_q[hit_idx] == bus.load_addr) && (bus.load_mode == WORD);
        bus.load_conflict = bus.load_query && hit && !fwd_ok;
        bus.fwd_valid     = bus.load_query && fwd_ok;
        bus.fwd_data      = (bus.load_query && fwd_ok) ? data_q[hit_idx] : '0;
    end
`else
    logic unused_nofwd;

    assign unused_nofwd      = ^{bus.load_mode, bus.load_addr[1:0]};
    assign bus.load_conflict = bus.load_query && hit;
    assign bus.fwd_valid     = 1'b0;
    assign bus.fwd_data      = '0;
`endif

endmodule

// File: tb/tb_store_drain_queue.sv
// Directed bench for store_drain_queue: per-cycle vector table, then wrap-around
// and reset-in-drain sequences checked against a FIFO of expected drains.
module tb_store_drain_queue;
    import store_drain_queue_pkg::*;

`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        se;
        ldst_mode    smode;
        logic [31:0] saddr;
        logic [31:0] sdata;
        logic        ack;
        logic        lq;
        ldst_mode    lmode;
        logic [31:0] laddr;
        logic        e_req;
        ldst_mode    e_mode;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
        logic        e_conf;
        logic        e_fwdv;
        logic [31:0] e_fwdd;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    drain_state_t dbg_state;
    int           checks   = 0;
    int           failures = 0;
    logic [63:0]  exp_q[$];
    vec_t         vecs[$];

    store_drain_queue_if bus ();

    store_drain_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    function automatic vec_t mk(
        logic se, ldst_mode smode, logic [31:0] saddr, logic [31:0] sdata, logic ack,
        logic lq, ldst_mode lmode, logic [31:0] laddr,
        logic e_req, ldst_mode e_mode, logic [31:0] e_addr, logic [31:0] e_data,
        logic e_full, logic e_empty, logic e_ovf, logic e_conf, logic e_fwdv, logic [31:0] e_fwdd);
        vec_t v;
        v.se = se; v.smode = smode; v.saddr = saddr; v.sdata = sdata; v.ack = ack;
        v.lq = lq; v.lmode = lmode; v.laddr = laddr;
        v.e_req = e_req; v.e_mode = e_mode; v.e_addr = e_addr; v.e_data = e_data;
        v.e_full = e_full; v.e_empty = e_empty; v.e_ovf = e_ovf;
        v.e_conf = e_conf; v.e_fwdv = e_fwdv; v.e_fwdd = e_fwdd;
        return v;
    endfunction

    // Driver tasks
    task automatic drive(input logic se, input ldst_mode smode, input logic [31:0] saddr,
                         input logic [31:0] sdata, input logic ack, input logic lq,
                         input ldst_mode lmode, input logic [31:0] laddr);
        bus.store_enable = se;
        bus.store_mode   = smode;
        bus.store_addr   = saddr;
        bus.store_data   = sdata;
        bus.mem_ack      = ack;
        bus.load_query   = lq;
        bus.load_mode    = lmode;
        bus.load_addr    = laddr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.mem_req", i),  32'(bus.mem_req),       32'(v.e_req));
        chk($sformatf("v%0d.mem_mode", i), 32'(bus.mem_mode),      32'(v.e_mode));
        chk($sformatf("v%0d.mem_addr", i), bus.mem_addr,           v.e_addr);
        chk($sformatf("v%0d.mem_data", i), bus.mem_data,           v.e_data);
        chk($sformatf("v%0d.full", i),     32'(bus.full),          32'(v.e_full));
        chk($sformatf("v%0d.empty", i),    32'(bus.empty),         32'(v.e_empty));
        chk($sformatf("v%0d.overflow", i), 32'(bus.overflow),      32'(v.e_ovf));
        chk($sformatf("v%0d.conflict", i), 32'(bus.load_conflict), 32'(v.e_conf));
        chk($sformatf("v%0d.fwd_valid", i),32'(bus.fwd_valid),     32'(v.e_fwdv));
        chk($sformatf("v%0d.fwd_data", i), bus.fwd_data,           v.e_fwdd);
    endtask

    initial begin
        int          pushed;
        int          cyc;
        logic        do_push;
        logic [31:0] d;
        logic [63:0] e;

        reset = 1'b1;
        drive(0, BYTE, 0, 0, 0, 0, BYTE, 0);
        repeat (2) @(negedge clk);
        #1 chk("reset.state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;

        // se mode addr data ack | lq lmode laddr | req mode addr data full empty ovf conf fwdv fwdd
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  0, BYTE, 0,  0, BYTE, 0, 0, 0, 1, 0, 0, 0, 0));
        // single store with ack held high
        vecs.push_back(mk(1, WORD, 32'h100, 32'hDEADBEEF, 1,  0, BYTE, 0,  0, BYTE, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 1,  1, WORD, 32'h100,
                          1, WORD, 32'h100, 32'hDEADBEEF, 0, 0, 0, !FWD, FWD, FWD ? 32'hDEADBEEF : 32'h0));
        vecs.push_back(mk(0, BYTE, 0, 0, 1,  1, WORD, 32'h100,  0, BYTE, 0, 0, 0, 1, 0, 0, 0, 0));
        // fill with no ack, drop a 5th, then push alongside an ack
        vecs.push_back(mk(1, WORD, 32'h400, 32'hA0, 0,  0, BYTE, 0,  0, BYTE, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, WORD, 32'h404, 32'hA1, 0,  0, BYTE, 0,  1, WORD, 32'h400, 32'hA0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, WORD, 32'h408, 32'hA2, 0,  0, BYTE, 0,  1, WORD, 32'h400, 32'hA0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, WORD, 32'h40C, 32'hA3, 0,  0, BYTE, 0,  1, WORD, 32'h400, 32'hA0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, WORD, 32'h410, 32'hA4, 0,  0, BYTE, 0,  1, WORD, 32'h400, 32'hA0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  1, WORD, 32'h410,  1, WORD, 32'h400, 32'hA0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, WORD, 32'h414, 32'hA5, 1,  0, BYTE, 0,  1, WORD, 32'h400, 32'hA0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 1,  0, BYTE, 0,  1, WORD, 32'h404, 32'hA1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 1,  0, BYTE, 0,  1, WORD, 32'h408, 32'hA2, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 1,  0, BYTE, 0,  1, WORD, 32'h40C, 32'hA3, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 1,  0, BYTE, 0,  1, WORD, 32'h414, 32'hA5, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  0, BYTE, 0,  0, BYTE, 0, 0, 0, 1, 1, 0, 0, 0));
        // byte store conflict probes
        vecs.push_back(mk(1, BYTE, 32'h203, 32'h55, 0,  0, BYTE, 0,  0, BYTE, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  1, WORD, 32'h200,  1, BYTE, 32'h203, 32'h55, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  1, WORD, 32'h204,  1, BYTE, 32'h203, 32'h55, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  1, BYTE, 32'h203,  1, BYTE, 32'h203, 32'h55, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 1,  0, WORD, 32'h200,  1, BYTE, 32'h203, 32'h55, 0, 0, 1, 0, 0, 0));
        // forwarding: two word stores to the same address
        vecs.push_back(mk(1, WORD, 32'h300, 32'h11111111, 0,  0, BYTE, 0,  0, BYTE, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, WORD, 32'h300, 32'h22222222, 0,  1, WORD, 32'h300,
                          1, WORD, 32'h300, 32'h11111111, 0, 0, 1, !FWD, FWD, FWD ? 32'h11111111 : 32'h0));
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  1, WORD, 32'h300,
                          1, WORD, 32'h300, 32'h11111111, 0, 0, 1, !FWD, FWD, FWD ? 32'h22222222 : 32'h0));
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  1, HALF, 32'h300,  1, WORD, 32'h300, 32'h11111111, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  1, WORD, 32'h302,  1, WORD, 32'h300, 32'h11111111, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 1,  0, WORD, 32'h300,  1, WORD, 32'h300, 32'h11111111, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, BYTE, 0, 0, 1,  1, WORD, 32'h300,
                          1, WORD, 32'h300, 32'h22222222, 0, 0, 1, !FWD, FWD, FWD ? 32'h22222222 : 32'h0));
        vecs.push_back(mk(0, BYTE, 0, 0, 0,  1, WORD, 32'h300,  0, BYTE, 0, 0, 0, 1, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].se, vecs[i].smode, vecs[i].saddr, vecs[i].sdata, vecs[i].ack,
                  vecs[i].lq, vecs[i].lmode, vecs[i].laddr);
            #1 check_vec(i, vecs[i]);
        end

        // Wrap-around: 10 stores, mem_ack toggling every cycle, drains in push order.
        pushed = 0;
        cyc    = 0;
        while ((pushed < 10 || exp_q.size() != 0) && cyc < 200) begin
            @(negedge clk);
            do_push = (pushed < 10) && !bus.full;
            d = $urandom;
            drive(do_push, WORD, 32'h1000 + 32'(pushed) * 4, d, cyc[0], 0, BYTE, 0);
            #1;
            if (bus.mem_req && bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    chk("wrap.unexpected_pop", 32'(bus.mem_req), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wrap.mem_addr", bus.mem_addr, e[63:32]);
                    chk("wrap.mem_data", bus.mem_data, e[31:0]);
                end
            end
            if (do_push) begin
                exp_q.push_back({32'h1000 + 32'(pushed) * 4, d});
                pushed++;
            end
            cyc++;
        end
        chk("wrap.timeout", 32'(cyc < 200), 32'h1);
        @(negedge clk);
        drive(0, BYTE, 0, 0, 0, 0, BYTE, 0);
        #1 chk("wrap.empty_after", 32'(bus.empty), 32'h1);
        chk("wrap.req_after", 32'(bus.mem_req), 32'h0);

        // Reset in mid-drain with three entries pending and mem_ack high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, WORD, 32'h600 + 32'(i) * 4, 32'h600 + 32'(i), 0, 0, BYTE, 0);
        end
        @(negedge clk);
        drive(0, BYTE, 0, 0, 1, 0, BYTE, 0);
        #1 chk("rst.pre_req", 32'(bus.mem_req), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst.mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst.empty", 32'(bus.empty), 32'h1);
        chk("rst.overflow", 32'(bus.overflow), 32'h0);
        chk("rst.state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        drive(1, WORD, 32'h700, 32'hCAFEF00D, 1, 0, BYTE, 0);
        #1 chk("rst.idle_req", 32'(bus.mem_req), 32'h0);
        @(negedge clk);
        drive(0, BYTE, 0, 0, 1, 0, BYTE, 0);
        #1 chk("rst.post_req", 32'(bus.mem_req), 32'h1);
        chk("rst.post_addr", bus.mem_addr, 32'h700);
        chk("rst.post_data", bus.mem_data, 32'hCAFEF00D);
        @(negedge clk);
        #1 chk("rst.drained_empty", 32'(bus.empty), 32'h1);
        chk("rst.drained_req", 32'(bus.mem_req), 32'h0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_drain_queue.md
# store_drain_queue

Commit-side store buffer between the commit stage and the data-memory write port. Accepts at most one committed store per cycle (store_enable/store_mode/store_addr/store_data from commit), holds it in a circular FIFO, and drains entries in order to memory over a req/ack handshake. Also answers a combinational address query from the load unit, so loads never bypass an older, undrained store.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- DEPTH_LOG, $clog2(DEPTH): pointer width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- store_enable  in  1  commit stage presents a store this cycle.
- store_mode  in  ldst_mode  width of the committed store.
- store_addr  in  32  store byte address.
- store_data  in  32  store data, right-aligned.
- full  out  1  count == DEPTH. Commit must not assert store_enable unless a pop happens the same cycle.
- empty  out  1  count == 0. Used for fences.
- overflow  out  1  sticky; set when a store is dropped.
- mem_req  out  1  head entry valid on mem_* lines.
- mem_ack  in  1  memory accepted the head this cycle.
- mem_mode  out  ldst_mode  head mode.
- mem_addr  out  32  head address.
- mem_data  out  32  head data.
- load_query  in  1  load unit is probing.
- load_mode  in  ldst_mode  probing load width.
- load_addr  in  32  probing load address.
- load_conflict  out  1  load must stall this cycle.
- fwd_valid  out  1  fwd_data is valid; the load may complete with it.
- fwd_data  out  32  forwarded store data.

## Operation
- Storage: DEPTH entries {mode, addr, data}. Head and tail pointers are DEPTH_LOG bits and wrap naturally. count is DEPTH_LOG+1 bits.
- Push: on an edge with store_enable=1 and (count<DEPTH or a pop on the same edge), write the entry at tail and increment tail.
- Dropped store: store_enable=1 with count==DEPTH and no pop on that edge. Nothing is written and overflow is set. overflow is cleared only by reset.
- Pop: on an edge with state==REQ and mem_ack=1, increment head.
- Simultaneous push and pop: count is unchanged. This is legal when full.
- Drain FSM states:
  - IDLE: mem_req=0. Go to REQ when count!=0 at the edge, counting a push on that edge.
  - REQ: mem_req=1. mem_mode/addr/data equal the head entry and stay stable until acked.
    - On ack with post-pop count==0: go to IDLE.
    - Otherwise stay in REQ; the next head is presented the following cycle.
- mem_ack is ignored in IDLE.
- Query match: a registered valid entry whose addr[31:2] equals load_addr[31:2]. The check is word-granular and conservative. The head entry under drain still counts until popped. A store pushed on the same cycle is not visible to the query.
- load_conflict, fwd_valid and fwd_data are 0 whenever load_query=0.

## Timing
- Reset values: head=tail=count=0, state=IDLE, mem_req=0, full=0, empty=1, overflow=0, load_conflict=0, fwd_valid=0, mem_*/fwd_data=0.
- Push at edge N: empty falls and mem_req rises in cycle N+1. The earliest pop is at edge N+1 if mem_ack=1.
- Back-to-back acks drain one entry per cycle. mem_req stays high continuously.
- full and empty are derived from the registered count (no combinational path from store_enable).
- mem_* outputs come from registers and pointers only.
- Query outputs are combinational from load_* and the FIFO contents, with zero latency.
- Reset in mid-drain discards every entry. mem_req is 0 in the cycle after reset is sampled, even if mem_ack was high.

## Configuration
- STORE_FWD_EN defined:
  - Forwarding happens when the youngest matching entry has mode WORD, its addr equals load_addr exactly, and load_mode==WORD. Then fwd_valid=1, fwd_data=entry data, load_conflict=0.
  - Any other match gives load_conflict=1 and fwd_valid=0.
- STORE_FWD_EN undefined:
  - fwd_valid=0 and fwd_data=0 always.
  - load_conflict=1 on any match.

## Test plan
- Single store: push WORD 0x100/0xDEADBEEF with mem_ack held high.
  - Required: mem_req=1 the next cycle with mem_addr=0x100 and mem_data=0xDEADBEEF.
  - The entry pops on that edge and empty=1 one cycle later.
- Fill and stall: push 4 stores with mem_ack=0.
  - Required: full=1, mem_addr stable at the first store's address.
  - A 5th push with no ack sets overflow=1 and count stays 4.
  - A 5th push together with an ack is accepted; drain order is FIFO.
- Wrap-around: 10 stores with mem_ack toggling every cycle.
  - Required: all 10 addresses appear on mem_addr in push order, and no entry repeats or is lost.
- Conflict: buffer holds BYTE 0x203. A WORD load query at 0x200 gives load_conflict=1 and fwd_valid=0. A query at 0x204 gives load_conflict=0.
- Forwarding, with STORE_FWD_EN: WORD 0x300/0x11111111 then WORD 0x300/0x22222222 pending. A WORD query at 0x300 gives fwd_valid=1, fwd_data=0x22222222, load_conflict=0. Without the macro, load_conflict=1.
- Reset in mid-drain: 3 entries pending with mem_ack=1, then reset asserted.
  - Required: next cycle mem_req=0, empty=1, overflow=0.
  - A subsequent push drains normally.
